// File: rtl/cpu_cmd_feeder.sv
// rtl/cpu_cmd_feeder.sv - host command FIFO feeding a CPU with ack/done timeouts
// Commands queue in a small FIFO, issue one at a time and return one held response.
module cpu_cmd_feeder #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ACK_TMO  = 16,
  parameter int DONE_TMO = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [6:0]         req_cmd,
  input  logic [WIDTH-1:0]   req_d1,
  input  logic [WIDTH-1:0]   req_d2,
  input  logic [WIDTH-1:0]   req_d3,
  input  logic [WIDTH-1:0]   req_d4,
  input  logic               cpu_rdy,
  output logic [6:0]         cmd_in,
  output logic [WIDTH-1:0]   din_1,
  output logic [WIDTH-1:0]   din_2,
  output logic [WIDTH-1:0]   din_3,
  output logic [WIDTH-1:0]   din_4,
  input  logic [2*WIDTH-1:0] out_reg3,
  input  logic               zero,
  input  logic               error,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_zero,
  output logic               rsp_error,
  output logic               rsp_timeout,
  output logic               busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int EW = 7 + 4 * WIDTH;
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TMO - 1);
  localparam logic [7:0] DONE_LAST = 8'(DONE_TMO - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP} state_t;
  state_t state, state_nxt;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr;
  logic          full, empty, push, start, ready_en;
  logic [EW-1:0] iss_q;
  logic [7:0]    tmo_cnt;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // ready_en keeps req_ready low through reset and for the first edge after it
  assign req_ready = ready_en && !full;
  assign push      = req_valid && req_ready;
  assign start     = (state == IDLE) && !empty && cpu_rdy && !rsp_valid;

  assign {din_1, din_2, din_3, din_4} = iss_q[4*WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {req_cmd, req_d1, req_d2, req_d3, req_d4};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push)  wr_ptr <= wr_ptr + 1'b1;
      if (start) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cmd_in    = 7'd0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nxt = ISSUE;
      ISSUE: begin
        cmd_in    = iss_q[EW-1 -: 7];
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!cpu_rdy)                  state_nxt = WAIT_DONE;
        else if (tmo_cnt >= ACK_LAST)  state_nxt = RESP;
      end
      WAIT_DONE: if (cpu_rdy || tmo_cnt >= DONE_LAST) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= 8'd0;
      iss_q       <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      // cleared on every state change, saturates instead of wrapping
      if (state_nxt != state)   tmo_cnt <= 8'd0;
      else if (tmo_cnt != 8'hFF) tmo_cnt <= tmo_cnt + 8'd1;
      if (start) iss_q <= mem[rd_ptr[AW-1:0]];
      if (state == WAIT_ACK && state_nxt == RESP) begin
        rsp_valid   <= 1'b1;
        rsp_data    <= '0;
        rsp_zero    <= 1'b0;
        rsp_error   <= 1'b1;
        rsp_timeout <= 1'b1;
      end
      if (state == WAIT_DONE && state_nxt == RESP) begin
        rsp_valid <= 1'b1;
        if (cpu_rdy) begin
          rsp_data    <= out_reg3;
          rsp_zero    <= zero;
          rsp_error   <= error;
          rsp_timeout <= 1'b0;
        end else begin
          rsp_data    <= '0;
          rsp_zero    <= 1'b0;
          rsp_error   <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_cpu_cmd_feeder.sv
// tb/tb_cpu_cmd_feeder.sv - directed and randomized self-checking bench for cpu_cmd_feeder
module tb_cpu_cmd_feeder;
  localparam int W        = 8;
  localparam int D        = 4;
  localparam int ACK_TMO  = 16;
  localparam int DONE_TMO = 255;

  typedef struct packed {
    logic [6:0]   cmd;
    logic [W-1:0] d1, d2, d3, d4;
  } entry_t;

  logic clk = 1'b0;
  logic reset, req_valid, req_ready, cpu_rdy, zero, error;
  logic rsp_valid, rsp_ready, rsp_zero, rsp_error, rsp_timeout, busy;
  logic [6:0]     req_cmd, cmd_in;
  logic [W-1:0]   req_d1, req_d2, req_d3, req_d4;
  logic [W-1:0]   din_1, din_2, din_3, din_4;
  logic [2*W-1:0] out_reg3, rsp_data;

  int checks = 0;
  int failures = 0;
  entry_t model_q[$];
  logic [2*W-1:0] exp_data;
  logic exp_zero, exp_error, exp_tmo, chk_data, chk_zero;

  always #5 clk = ~clk;

  cpu_cmd_feeder #(.WIDTH(W), .DEPTH(D), .ACK_TMO(ACK_TMO), .DONE_TMO(DONE_TMO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3), .req_d4(req_d4),
    .cpu_rdy(cpu_rdy), .cmd_in(cmd_in),
    .din_1(din_1), .din_2(din_2), .din_3(din_3), .din_4(din_4),
    .out_reg3(out_reg3), .zero(zero), .error(error),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic entry_t rand_entry();
    entry_t e;
    e.cmd = 7'($urandom_range(1, 127));
    e.d1 = W'($urandom);
    e.d2 = W'($urandom);
    e.d3 = W'($urandom);
    e.d4 = W'($urandom);
    return e;
  endfunction

  task automatic push(input entry_t e);
    req_valid = 1'b1;
    {req_cmd, req_d1, req_d2, req_d3, req_d4} = e;
    check("req_ready", req_ready, model_q.size() < D);
    if (model_q.size() < D) model_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic check_rsp(input string tag);
    check({tag, "_error"}, rsp_error, exp_error);
    check({tag, "_timeout"}, rsp_timeout, exp_tmo);
    if (chk_data) check({tag, "_data"}, rsp_data, exp_data);
    if (chk_zero) check({tag, "_zero"}, rsp_zero, exp_zero);
  endtask

  // CPU behaviour: stays ready ack_dly cycles, is busy done_dly extra cycles, result = d1*d2
  task automatic serve(input int ack_dly, input int done_dly, input logic z, input logic e);
    int n, lat;
    bit ack_to, done_to;
    entry_t ent;
    logic [2*W-1:0] res;
    n = 0;
    while (cmd_in === 7'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait", n, 1);
    if (cmd_in === 7'd0 || model_q.size() == 0) begin
      if (model_q.size() == 0) check("unexpected_cmd", cmd_in, 0);
      model_q.delete();
      return;
    end
    ent = model_q.pop_front();
    check("cmd_in", cmd_in, ent.cmd);
    check("din", {din_1, din_2, din_3, din_4}, {ent.d1, ent.d2, ent.d3, ent.d4});
    check("busy", busy, 1);
    res = ent.d1 * ent.d2;
    ack_to  = (ack_dly >= ACK_TMO);
    done_to = !ack_to && (done_dly >= DONE_TMO);
    if (ack_to)       lat = 1 + ACK_TMO;
    else if (done_to) lat = 2 + ack_dly + DONE_TMO;
    else              lat = 3 + ack_dly + done_dly;
    for (int t = 1; t <= lat; t++) begin
      @(negedge clk);
      if (t < lat) begin
        check("rsp_valid_early", rsp_valid, 0);
        check("cmd_in_pulse", cmd_in, 0);
        check("din_hold", {din_1, din_2, din_3, din_4}, {ent.d1, ent.d2, ent.d3, ent.d4});
      end
      if (ack_to || t <= ack_dly)            cpu_rdy = 1'b1;
      else if (t <= ack_dly + 1 + done_dly)  cpu_rdy = 1'b0;
      else                                   cpu_rdy = 1'b1;
      if (!ack_to && !done_to && t == ack_dly + 2 + done_dly) begin
        out_reg3 = res;
        zero = z;
        error = e;
      end else begin
        out_reg3 = 16'($urandom);
        zero = 1'($urandom);
        error = 1'($urandom);
      end
    end
    check("rsp_valid", rsp_valid, 1);
    chk_data  = !ack_to;
    chk_zero  = !ack_to && !done_to;
    exp_data  = done_to ? '0 : res;
    exp_zero  = z;
    exp_error = (ack_to || done_to) ? 1'b1 : e;
    exp_tmo   = ack_to || done_to;
    check_rsp("rsp");
    cpu_rdy = 1'b1;
  endtask

  task automatic consume(input int hold);
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      out_reg3 = 16'($urandom);
      zero = 1'($urandom);
      error = 1'($urandom);
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_no_issue", cmd_in, 0);
      check_rsp("hold");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_consumed", rsp_valid, 0);
    check("busy_idle", busy, 0);
  endtask

  initial begin
    entry_t e;
    int k, n;
    reset = 1'b1; req_valid = 1'b0; {req_cmd, req_d1, req_d2, req_d3, req_d4} = '0;
    cpu_rdy = 1'b1; out_reg3 = '0; zero = 1'b0; error = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_in", cmd_in, 0);
    check("rst_din", {din_1, din_2, din_3, din_4}, 0);
    check("rst_rsp_fields", {rsp_data, rsp_zero, rsp_error, rsp_timeout}, 0);
    reset = 1'b0;
    #1 check("ready_before_edge", req_ready, 0);
    @(negedge clk);
    check("ready_after_edge", req_ready, 1);

    // single command, minimum latency
    e = '{cmd: 7'h05, d1: 8'd3, d2: 8'd4, d3: 8'd0, d4: 8'd0};
    push(e);
    serve(0, 0, 1'b0, 1'b0);
    check("single_data", rsp_data, 16'h000C);
    consume(0);

    // error and zero passthrough
    push(rand_entry());
    serve(0, 2, 1'b1, 1'b1);
    consume(1);

    // ack timeout and done timeout
    push(rand_entry());
    serve(ACK_TMO, 0, 1'b0, 1'b0);
    consume(0);
    push(rand_entry());
    serve(0, DONE_TMO, 1'b0, 1'b0);
    consume(0);

    // FIFO full: fifth push refused, then in-order issue
    cpu_rdy = 1'b0;
    for (int i = 0; i < D + 1; i++) push(rand_entry());
    cpu_rdy = 1'b1;
    while (model_q.size() > 0) begin
      serve(1, 1, 1'b0, 1'b0);
      consume(0);
    end

    // response backpressure with a second command queued
    cpu_rdy = 1'b0;
    push(rand_entry());
    push(rand_entry());
    cpu_rdy = 1'b1;
    serve(1, 1, 1'b0, 1'b1);
    consume(10);
    serve(0, 0, 1'b1, 1'b0);
    consume(0);

    // randomized batches
    for (int b = 0; b < 12; b++) begin
      k = $urandom_range(1, D + 1);
      cpu_rdy = 1'b0;
      for (int i = 0; i < k; i++) push(rand_entry());
      cpu_rdy = 1'b1;
      while (model_q.size() > 0) begin
        serve($urandom_range(0, 3), $urandom_range(0, 5), 1'($urandom), 1'($urandom));
        consume($urandom_range(0, 3));
      end
    end

    // reset while in WAIT_DONE with another command still queued
    cpu_rdy = 1'b0;
    push(rand_entry());
    push(rand_entry());
    cpu_rdy = 1'b1;
    n = 0;
    while (cmd_in === 7'd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("mid_issue_wait", n, 1);
    @(negedge clk);
    cpu_rdy = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_cmd_in", cmd_in, 0);
    check("mid_din", {din_1, din_2, din_3, din_4}, 0);
    check("mid_rsp", {rsp_valid, rsp_data, rsp_zero, rsp_error, rsp_timeout}, 0);
    check("mid_busy_rst", busy, 0);
    check("mid_req_ready", req_ready, 0);
    @(negedge clk);
    reset = 1'b0;
    model_q.delete();
    cpu_rdy = 1'b1;
    @(negedge clk);
    check("mid_ready_after", req_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_fifo_empty", {busy, cmd_in}, 0);
    end

    // normal operation after reset
    push(rand_entry());
    serve(2, 3, 1'b0, 1'b0);
    consume(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
